// File: rtl/maxpool2x2_stream_pkg.sv
// Shared constants and helpers for the YOLOv7-UAV streaming pool stage:
// default geometry, counter/address width helpers and the unsigned max
// used by the pooling datapath.
package yolo_stage_pkg;

   localparam int DEF_DATAWIDTH = 8;
   localparam int DEF_N         = 320;
   localparam int DEF_DEPTH     = 3;

   // Widest element the max helper handles; callers zero-extend into it.
   localparam int MAX_W = 64;

   // Bits for a column/row counter counting 0..n-1 (at least 1).
   function automatic int col_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Bits for a channel counter counting 0..d-1 (at least 1).
   function automatic int ch_width(input int d);
      return (d < 2) ? 1 : $clog2(d);
   endfunction

   // Address bits for the (n/2)*d word line buffer (at least 1).
   function automatic int lb_addr_width(input int n, input int d);
      int words;
      words = (n / 2) * d;
      return (words < 2) ? 1 : $clog2(words);
   endfunction

   // Unsigned maximum; ties return the common value.
   function automatic logic [MAX_W-1:0] umax(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Valid/ready element stream used on both sides of the pool stage.
interface maxpool2x2_stream_if #(
   parameter int DATAWIDTH = 8
);
   logic                 valid;
   logic                 ready;
   logic [DATAWIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/maxpool2x2_stream_pool_line_buffer.sv
// Simple dual-port line buffer: one synchronous write port, one
// combinational read port. Kept separate so a BRAM macro can replace it.
module pool_line_buffer
   import yolo_stage_pkg::*;
#(
   parameter int DEPTH_WORDS = (DEF_N / 2) * DEF_DEPTH,
   parameter int DATAWIDTH   = DEF_DATAWIDTH,
   localparam int ADDR_W     = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS)
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATAWIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [DATAWIDTH-1:0] rd_data
);

   logic [DATAWIDTH-1:0] mem [DEPTH_WORDS];

   // Store one horizontal partial max per (pooled column, channel).
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool. Even columns park in hbuf, odd columns
// form the horizontal max; even rows park that in the line buffer and odd
// rows combine it into the pooled output held in a one-entry register.
module maxpool2x2_stream
   import yolo_stage_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int N         = DEF_N,
   parameter int DEPTH     = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   maxpool2x2_stream_if.slave      in_stream,
   maxpool2x2_stream_if.master     out_stream,
   output logic                    frame_done
);

   localparam int COL_W  = col_width(N);
   localparam int CH_W   = ch_width(DEPTH);
   localparam int WORDS  = (N / 2) * DEPTH;
   localparam int ADDR_W = lb_addr_width(N, DEPTH);
   localparam logic [COL_W-1:0] LAST_POS = COL_W'(N - 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(DEPTH - 1);

   logic [CH_W-1:0]      ch;
   logic [COL_W-1:0]     col;
   logic [COL_W-1:0]     row;
   logic [DATAWIDTH-1:0] hbuf [DEPTH];

   logic                 out_valid;
   logic                 out_last;
   logic [DATAWIDTH-1:0] out_data;

   logic                 accept;
   logic                 lb_wr;
   logic                 load;
   logic                 frame_last;
   logic [DATAWIDTH-1:0] h;
   logic [DATAWIDTH-1:0] lb_rd;
   logic [ADDR_W-1:0]    lb_addr;

   // Input is taken only when the output slot is free or being emptied.
   assign in_stream.ready = en && (!out_valid || out_stream.ready);
   assign accept          = in_stream.valid && in_stream.ready;

   assign h       = DATAWIDTH'(umax(MAX_W'(hbuf[ch]), MAX_W'(in_stream.data)));
   assign lb_addr = ADDR_W'(32'(col >> 1) * DEPTH + 32'(ch));
   assign lb_wr   = accept && col[0] && !row[0];
   assign load    = accept && col[0] && row[0];
   assign frame_last = (row == LAST_POS) && (col == LAST_POS) && (ch == LAST_CH);

   // Raster position: channel innermost, then column, then row.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ch  <= '0;
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (ch == LAST_CH) begin
            ch <= '0;
            if (col == LAST_POS) begin
               col <= '0;
               row <= (row == LAST_POS) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            ch <= ch + 1'b1;
         end
      end
   end

   // Hold the even-column element of each channel until its odd partner.
   always_ff @(posedge clk) begin
      if (accept && !col[0]) hbuf[ch] <= in_stream.data;
   end

   // One-entry output register; load wins over drain in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= DATAWIDTH'(umax(MAX_W'(lb_rd), MAX_W'(h)));
         out_last  <= frame_last;
      end else if (out_stream.ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_stream.valid = out_valid;
   assign out_stream.data  = out_data;
   assign frame_done       = out_valid && out_stream.ready && out_last;

   pool_line_buffer #(
      .DEPTH_WORDS (WORDS),
      .DATAWIDTH   (DATAWIDTH)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (lb_wr),
      .wr_addr (lb_addr),
      .wr_data (h),
      .rd_addr (lb_addr),
      .rd_data (lb_rd)
   );

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4x1 instance and a 4x4x2 instance,
// checked against a plain-arithmetic pooling reference.
module tb_maxpool2x2_stream;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn_a, en_a, fd_a;
   logic rstn_b, en_b, fd_b;

   maxpool2x2_stream_if #(.DATAWIDTH(8)) a_in ();
   maxpool2x2_stream_if #(.DATAWIDTH(8)) a_out ();
   maxpool2x2_stream_if #(.DATAWIDTH(8)) b_in ();
   maxpool2x2_stream_if #(.DATAWIDTH(8)) b_out ();

   maxpool2x2_stream #(.DATAWIDTH(8), .N(4), .DEPTH(1)) dut_a (
      .clk(clk), .rstn(rstn_a), .en(en_a),
      .in_stream(a_in), .out_stream(a_out), .frame_done(fd_a));

   maxpool2x2_stream #(.DATAWIDTH(8), .N(4), .DEPTH(2)) dut_b (
      .clk(clk), .rstn(rstn_b), .en(en_b),
      .in_stream(b_in), .out_stream(b_out), .frame_done(fd_b));

   int  vectors = 0;
   int  miscompares = 0;
   bq_t got_a, got_b;
   bit  last_a[$];
   int  fd_cnt_a = 0, fd_cnt_b = 0;
   int  en_leak = 0, drive_timeout = 0;

   // Output monitor: record every downstream handshake and frame_done pulse.
   always @(negedge clk) begin
      if (a_out.valid === 1'b1 && a_out.ready === 1'b1) begin
         got_a.push_back(a_out.data);
         last_a.push_back(fd_a === 1'b1);
      end
      if (b_out.valid === 1'b1 && b_out.ready === 1'b1) got_b.push_back(b_out.data);
      if (fd_a === 1'b1) fd_cnt_a++;
      if (fd_b === 1'b1) fd_cnt_b++;
   end

   // Reference: each output is the max of its 2x2 window, per channel.
   function automatic bq_t pool_ref(input bq_t f, input int n, input int d);
      bq_t q;
      logic [7:0] m, v;
      q = {};
      for (int r = 0; r < n / 2; r++)
         for (int c = 0; c < n / 2; c++)
            for (int ch = 0; ch < d; ch++) begin
               m = 8'd0;
               for (int dr = 0; dr < 2; dr++)
                  for (int dc = 0; dc < 2; dc++) begin
                     v = f[((2 * r + dr) * n + 2 * c + dc) * d + ch];
                     if (v > m) m = v;
                  end
               q.push_back(m);
            end
      return q;
   endfunction

   task automatic step_a(input logic v, input logic [7:0] d, output logic acc);
      a_in.valid = v;
      a_in.data  = d;
      @(negedge clk);
      acc = v && (a_in.ready === 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic step_b(input logic v, input logic [7:0] d, output logic acc);
      b_in.valid = v;
      b_in.data  = d;
      @(negedge clk);
      acc = v && (b_in.ready === 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic drive_range_a(input bq_t f, input int lo, input int hi,
                                input bit gaps, input bit en_lows);
      int s1, s2, tries;
      logic acc;
      s1 = $urandom_range(hi, lo);
      s2 = $urandom_range(hi, lo);
      for (int k = lo; k <= hi; k++) begin
         if (en_lows && (k == s1 || k == s2)) begin
            en_a = 1'b0;
            repeat (3) begin
               step_a(1'b1, f[k], acc);
               if (acc) en_leak++;
            end
            en_a = 1'b1;
         end
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 100) begin
            if (gaps && $urandom_range(0, 2) == 0) step_a(1'b0, f[k], acc);
            else step_a(1'b1, f[k], acc);
            tries++;
         end
         if (!acc) drive_timeout++;
      end
      a_in.valid = 1'b0;
   endtask

   task automatic drive_b(input bq_t f);
      int tries;
      logic acc;
      for (int k = 0; k < f.size(); k++) begin
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 100) begin
            step_b(1'b1, f[k], acc);
            tries++;
         end
         if (!acc) drive_timeout++;
      end
      b_in.valid = 1'b0;
   endtask

   task automatic wait_a(input int n);
      for (int i = 0; i < 300 && got_a.size() < n; i++) begin
         @(posedge clk); #1;
      end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic wait_b(input int n);
      for (int i = 0; i < 300 && got_b.size() < n; i++) begin
         @(posedge clk); #1;
      end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rstn_a = 1'b0; rstn_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
      a_in.valid = 1'b0; a_in.data = 8'd0; a_out.ready = 1'b1;
      b_in.valid = 1'b0; b_in.data = 8'd0; b_out.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (a_out.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid_a: got %b want 0", a_out.valid); end
      vectors++; if (a_out.data !== 8'd0) begin miscompares++; $display("FAIL reset_data_a: got %0d want 0", a_out.data); end
      vectors++; if (fd_a !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done_a: got %b want 0", fd_a); end
      vectors++; if (b_out.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid_b: got %b want 0", b_out.valid); end
      vectors++; if (b_out.data !== 8'd0) begin miscompares++; $display("FAIL reset_data_b: got %0d want 0", b_out.data); end
      vectors++; if (a_in.ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_a: got %b want 1", a_in.ready); end
      en_a = 1'b0; #1;
      vectors++; if (a_in.ready !== 1'b0) begin miscompares++; $display("FAIL en_low_in_ready_a: got %b want 0", a_in.ready); end
      en_a = 1'b1;
      rstn_a = 1'b1; rstn_b = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_raster();
      bq_t f, exp;
      int fd0, idx, tries;
      logic acc;
      f = {};
      for (int k = 0; k < 16; k++) f.push_back(8'(k));
      exp = pool_ref(f, 4, 1);
      got_a = {}; last_a = {}; fd0 = fd_cnt_a; idx = 0;
      for (int k = 0; k < 16; k++) begin
         acc = 1'b0; tries = 0;
         while (!acc && tries < 100) begin step_a(1'b1, f[k], acc); tries++; end
         if (!acc) drive_timeout++;
         if (((k / 4) % 2 == 1) && (k % 2 == 1)) begin
            vectors++;
            if (a_out.valid !== 1'b1 || a_out.data !== exp[idx]) begin
               miscompares++;
               $display("FAIL raster_latency[%0d]: got valid=%b data=%0d want valid=1 data=%0d", idx, a_out.valid, a_out.data, exp[idx]);
            end
            idx++;
         end
      end
      a_in.valid = 1'b0;
      wait_a(exp.size());
      vectors++; if (got_a.size() != exp.size()) begin miscompares++; $display("FAIL raster_count: got %0d want %0d", got_a.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_a.size()) ? got_a[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL raster_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_a - fd0 != 1) begin miscompares++; $display("FAIL raster_frame_done: got %0d pulses want 1", fd_cnt_a - fd0); end
      vectors++; if (last_a.size() != 4 || last_a[3] !== 1'b1 || last_a[0] !== 1'b0) begin miscompares++; $display("FAIL raster_frame_done_pos: pulse not on last element only"); end
   endtask

   task automatic test_channels();
      bq_t f, exp;
      int fd0;
      f = {};
      for (int k = 0; k < 16; k++) begin f.push_back(8'(k)); f.push_back(8'(255 - k)); end
      exp = pool_ref(f, 4, 2);
      for (int k = 0; k < 32; k++) f.push_back(8'($urandom_range(255, 0)));
      exp = {exp, pool_ref(f[32:63], 4, 2)};
      got_b = {}; fd0 = fd_cnt_b;
      drive_b(f);
      wait_b(exp.size());
      vectors++; if (got_b.size() != exp.size()) begin miscompares++; $display("FAIL channels_count: got %0d want %0d", got_b.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_b.size()) ? got_b[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL channels_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_b - fd0 != 2) begin miscompares++; $display("FAIL channels_frame_done: got %0d pulses want 2", fd_cnt_b - fd0); end
   endtask

   task automatic test_backpressure();
      bq_t f, exp;
      int fd0;
      logic acc;
      f = {};
      for (int k = 0; k < 16; k++) f.push_back(8'(k));
      exp = pool_ref(f, 4, 1);
      got_a = {}; last_a = {}; fd0 = fd_cnt_a; drive_timeout = 0;
      a_out.ready = 1'b0;
      drive_range_a(f, 0, 5, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step_a(1'b1, f[6], acc);
         vectors++;
         if (acc !== 1'b0 || a_out.valid !== 1'b1 || a_out.data !== 8'd5) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got accept=%b valid=%b data=%0d want accept=0 valid=1 data=5", c, acc, a_out.valid, a_out.data);
         end
      end
      a_out.ready = 1'b1;
      drive_range_a(f, 6, 15, 1'b0, 1'b0);
      wait_a(exp.size());
      vectors++; if (got_a.size() != exp.size()) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", got_a.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_a.size()) ? got_a[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL stall_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_a - fd0 != 1 || drive_timeout != 0) begin miscompares++; $display("FAIL stall_frame_done: got %0d pulses (%0d timeouts) want 1 (0)", fd_cnt_a - fd0, drive_timeout); end
   endtask

   task automatic test_en_gaps();
      bq_t f, exp;
      int fd0;
      bit done;
      f = {};
      for (int k = 0; k < 16; k++) f.push_back(8'(k));
      exp = pool_ref(f, 4, 1);
      got_a = {}; last_a = {}; fd0 = fd_cnt_a; en_leak = 0; drive_timeout = 0; done = 1'b0;
      fork
         begin
            drive_range_a(f, 0, 15, 1'b1, 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               a_out.ready = 1'($urandom_range(1, 0));
               @(posedge clk); #1;
            end
            a_out.ready = 1'b1;
         end
      join
      wait_a(exp.size());
      vectors++; if (en_leak != 0) begin miscompares++; $display("FAIL en_low_accept: got %0d beats taken while disabled want 0", en_leak); end
      vectors++; if (got_a.size() != exp.size()) begin miscompares++; $display("FAIL en_count: got %0d want %0d", got_a.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_a.size()) ? got_a[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL en_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_a - fd0 != 1 || drive_timeout != 0) begin miscompares++; $display("FAIL en_frame_done: got %0d pulses (%0d timeouts) want 1 (0)", fd_cnt_a - fd0, drive_timeout); end
   endtask

   task automatic test_reset_mid();
      bq_t junk, f, exp;
      int fd0;
      junk = {};
      for (int k = 0; k < 7; k++) junk.push_back(8'($urandom_range(255, 0)));
      drive_range_a(junk, 0, 6, 1'b0, 1'b0);
      rstn_a = 1'b0;
      @(posedge clk); #1;
      rstn_a = 1'b1;
      vectors++; if (a_out.valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", a_out.valid); end
      f = {};
      for (int k = 0; k < 16; k++) f.push_back(8'd200);
      f[$urandom_range(15, 0)] = 8'd201;
      exp = pool_ref(f, 4, 1);
      got_a = {}; last_a = {}; fd0 = fd_cnt_a;
      drive_range_a(f, 0, 15, 1'b0, 1'b0);
      wait_a(exp.size());
      vectors++; if (got_a.size() != exp.size()) begin miscompares++; $display("FAIL midreset_count: got %0d want %0d", got_a.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_a.size()) ? got_a[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL midreset_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_a - fd0 != 1) begin miscompares++; $display("FAIL midreset_frame_done: got %0d pulses want 1", fd_cnt_a - fd0); end
   endtask

   task automatic test_back_to_back();
      bq_t f1, f2, exp;
      int fd0;
      f1 = {};
      for (int k = 0; k < 16; k++) f1.push_back(8'($urandom_range(255, 0)));
      f1[0] = 8'd0;   f1[1] = 8'd0; f1[4] = 8'd0;   f1[5] = 8'd0;
      f1[2] = 8'd255; f1[3] = 8'd0; f1[6] = 8'd255; f1[7] = 8'd255;
      f2 = {};
      for (int k = 0; k < 16; k++) f2.push_back(8'($urandom_range(255, 0)));
      exp = {pool_ref(f1, 4, 1), pool_ref(f2, 4, 1)};
      got_a = {}; last_a = {}; fd0 = fd_cnt_a;
      drive_range_a({f1, f2}, 0, 31, 1'b0, 1'b0);
      wait_a(exp.size());
      vectors++; if (got_a.size() != exp.size()) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", got_a.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         logic [7:0] g;
         g = (i < got_a.size()) ? got_a[i] : 8'hxx;
         vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, g, exp[i]); end
      end
      vectors++; if (fd_cnt_a - fd0 != 2) begin miscompares++; $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cnt_a - fd0); end
      vectors++; if (last_a.size() != 8 || last_a[3] !== 1'b1 || last_a[7] !== 1'b1) begin miscompares++; $display("FAIL b2b_frame_done_pos: pulses not on frame ends"); end
   endtask

   initial begin
      test_reset();
      test_raster();
      test_channels();
      test_backpressure();
      test_en_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
